// File: rtl/ahb_line_fill_ctrl.sv
// AHB-Lite read master for I-cache line refills: one linear burst of BEATS
// word reads per miss, assembled into a LINE_W line and returned with a ready pulse.
module ahb_line_fill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_data_in,
  output logic              mem_ready,
  output logic              fill_err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hburst,
  output logic [2:0]        hsize,
  output logic              hwrite,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  localparam int BEATS = LINE_W / DATA_W;
  localparam int BYTES = DATA_W / 8;
  localparam int CW    = $clog2(BEATS) + 1;
  localparam int BSH   = $clog2(BYTES);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [CW-1:0]     r_acnt;
  logic [CW-1:0]     r_dcnt;
  logic [LINE_W-1:0] r_line;
  logic              r_err;

  logic              w_start;
  logic              w_ainc;
  logic              w_cap;
  logic              w_err1;
  logic              w_more;

  assign w_more = (r_acnt < CW'(BEATS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // htrans drops to IDLE combinationally in the first error cycle so no
  // further SEQ is presented once the slave starts its two-cycle error.
  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    w_ainc  = 1'b0;
    w_cap   = 1'b0;
    w_err1  = 1'b0;
    htrans  = TR_IDLE;
    case (r_state)
      S_IDLE: begin
        if (mem_req) begin
          w_start = 1'b1;
          w_nxt   = S_ADDR;
        end
      end
      S_ADDR: begin
        htrans = TR_NONSEQ;
        if (hready) begin
          w_ainc = 1'b1;
          w_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (hresp && !hready) begin
          w_err1 = 1'b1;
          w_nxt  = S_ERR;
        end else begin
          if (w_more) htrans = TR_SEQ;
          if (hready) begin
            w_ainc = w_more;
            w_cap  = 1'b1;
            if (r_dcnt == CW'(BEATS - 1)) w_nxt = S_DONE;
          end
        end
      end
      S_ERR: begin
        if (hready) w_nxt = S_DONE;
      end
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base <= '0;
      r_acnt <= '0;
      r_dcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_base <= mem_addr & LINE_MASK;
        r_acnt <= '0;
        r_dcnt <= '0;
        r_err  <= 1'b0;
      end else begin
        if (w_ainc) r_acnt <= r_acnt + CW'(1);
        if (w_cap)  r_dcnt <= r_dcnt + CW'(1);
        if (w_err1) r_err  <= 1'b1;
        else if (r_state == S_DONE) r_err <= 1'b0;
      end
    end
  end

  // The line is not cleared on a new fill: old contents stay visible until
  // each slot is overwritten, and uncaptured slots survive an error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line <= '0;
    end else if (w_cap) begin
      for (int k = 0; k < BEATS; k++) begin
        if (r_dcnt == CW'(k)) r_line[k*DATA_W +: DATA_W] <= hrdata;
      end
    end
  end

  assign haddr       = r_base + (ADDR_W'(r_acnt) << BSH);
  assign hburst      = (BEATS == 4) ? 3'b011 : 3'b001;
  assign hsize       = 3'(BSH);
  assign hwrite      = 1'b0;
  assign mem_data_in = r_line;
  assign mem_ready   = (r_state == S_DONE);
  assign fill_err    = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_ahb_line_fill_ctrl.sv
// Directed bench for ahb_line_fill_ctrl: zero-wait, wait-state, error,
// back-to-back, reset-mid-burst and reset-release-with-request fills.
module tb_ahb_line_fill_ctrl;

  logic         clk;
  logic         rst;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data_in;
  logic         mem_ready;
  logic         fill_err;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic [2:0]   hsize;
  logic         hwrite;
  logic [31:0]  hrdata;
  logic         hready;
  logic         hresp;

  int checks   = 0;
  int failures = 0;

  ahb_line_fill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_W(128)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready), .fill_err(fill_err),
    .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize),
    .hwrite(hwrite), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; mem_req = 1'b0; mem_addr = '0;
    hrdata = '0; hready = 1'b1; hresp = 1'b0;
    #12;
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_err", fill_err, 1'b0);
    chk("rst_line", mem_data_in, 128'h0);
    chk("hburst", hburst, 3'b011);
    chk("hsize", hsize, 3'b010);
    chk("hwrite", hwrite, 1'b0);

    // 1: zero-wait fill
    @(posedge clk); #1; rst = 1'b1;
    mem_req = 1'b1; mem_addr = 32'h0000_1234;
    step(); #1;
    chk("t1_c1_htrans", htrans, 2'b10);
    chk("t1_c1_haddr", haddr, 32'h1230);
    step(); hrdata = 32'hA0; #1;
    chk("t1_c2_htrans", htrans, 2'b11);
    chk("t1_c2_haddr", haddr, 32'h1234);
    step(); hrdata = 32'hA1; #1;
    chk("t1_c3_htrans", htrans, 2'b11);
    chk("t1_c3_haddr", haddr, 32'h1238);
    step(); hrdata = 32'hA2; #1;
    chk("t1_c4_htrans", htrans, 2'b11);
    chk("t1_c4_haddr", haddr, 32'h123C);
    step(); hrdata = 32'hA3; #1;
    chk("t1_c5_htrans", htrans, 2'b00);
    chk("t1_c5_ready", mem_ready, 1'b0);
    step(); #1;
    chk("t1_c6_ready", mem_ready, 1'b1);
    chk("t1_c6_err", fill_err, 1'b0);
    chk("t1_c6_line", mem_data_in, 128'h000000A3_000000A2_000000A1_000000A0);
    step(); mem_req = 1'b0; #1;
    chk("t1_c7_ready", mem_ready, 1'b0);

    // 2: wait states on the NONSEQ and on beat 1
    step(); mem_req = 1'b1; mem_addr = 32'h0000_5678;
    step(); hready = 1'b0; #1;
    chk("t2_c1_htrans", htrans, 2'b10);
    chk("t2_c1_haddr", haddr, 32'h5670);
    step(); hready = 1'b1; #1;
    chk("t2_c2_htrans", htrans, 2'b10);
    chk("t2_c2_haddr", haddr, 32'h5670);
    step(); hrdata = 32'hB0; #1;
    chk("t2_c3_haddr", haddr, 32'h5674);
    step(); hready = 1'b0; hrdata = 32'hDEAD_BEEF; #1;
    chk("t2_c4_haddr", haddr, 32'h5678);
    step(); #1;
    chk("t2_c5_htrans", htrans, 2'b11);
    chk("t2_c5_haddr", haddr, 32'h5678);
    step(); hready = 1'b1; hrdata = 32'hB1; #1;
    chk("t2_c6_haddr", haddr, 32'h5678);
    step(); hrdata = 32'hB2; #1;
    chk("t2_c7_haddr", haddr, 32'h567C);
    step(); hrdata = 32'hB3; #1;
    chk("t2_c8_htrans", htrans, 2'b00);
    chk("t2_c8_ready", mem_ready, 1'b0);
    step(); #1;
    chk("t2_c9_ready", mem_ready, 1'b1);
    chk("t2_c9_line", mem_data_in, 128'h000000B3_000000B2_000000B1_000000B0);
    step(); mem_req = 1'b0;

    // 3: error response on beat 2
    step(); mem_req = 1'b1; mem_addr = 32'h0000_3000;
    step(); #1;
    chk("t3_c1_haddr", haddr, 32'h3000);
    step(); hrdata = 32'hC0; #1;
    step(); hrdata = 32'hC1; #1;
    chk("t3_c3_haddr", haddr, 32'h3008);
    step(); hresp = 1'b1; hready = 1'b0; hrdata = 32'hBAD0; #1;
    chk("t3_c4_htrans", htrans, 2'b00);
    chk("t3_c4_ready", mem_ready, 1'b0);
    step(); hready = 1'b1; #1;
    chk("t3_c5_htrans", htrans, 2'b00);
    step(); hresp = 1'b0; #1;
    chk("t3_c6_ready", mem_ready, 1'b1);
    chk("t3_c6_err", fill_err, 1'b1);
    chk("t3_c6_line", mem_data_in, 128'h000000B3_000000B2_000000C1_000000C0);
    step(); mem_req = 1'b0; #1;
    chk("t3_c7_htrans", htrans, 2'b00);
    chk("t3_c7_err", fill_err, 1'b0);

    // 4: back-to-back fills
    step(); mem_req = 1'b1; mem_addr = 32'h0000_1000;
    step();
    step(); hrdata = 32'hD0;
    step(); hrdata = 32'hD1;
    step(); hrdata = 32'hD2;
    step(); hrdata = 32'hD3; #1;
    step(); #1;
    chk("t4_c6_ready", mem_ready, 1'b1);
    chk("t4_c6_err", fill_err, 1'b0);
    chk("t4_c6_line", mem_data_in, 128'h000000D3_000000D2_000000D1_000000D0);
    step(); mem_req = 1'b0;
    step(); mem_req = 1'b1; mem_addr = 32'h0000_2000; #1;
    chk("t4_c8_htrans", htrans, 2'b00);
    step(); #1;
    chk("t4_c9_htrans", htrans, 2'b10);
    chk("t4_c9_haddr", haddr, 32'h2000);
    chk("t4_c9_line", mem_data_in, 128'h000000D3_000000D2_000000D1_000000D0);
    step(); hrdata = 32'hE0; #1;
    chk("t4_c10_line", mem_data_in, 128'h000000D3_000000D2_000000D1_000000D0);
    step(); hrdata = 32'hE1; #1;
    chk("t4_c11_line", mem_data_in, 128'h000000D3_000000D2_000000D1_000000E0);
    step(); hrdata = 32'hE2;
    step(); hrdata = 32'hE3;
    step(); #1;
    chk("t4_c14_ready", mem_ready, 1'b1);
    chk("t4_c14_line", mem_data_in, 128'h000000E3_000000E2_000000E1_000000E0);
    step(); mem_req = 1'b0;

    // 5: asynchronous reset mid-burst
    step(); mem_req = 1'b1; mem_addr = 32'h0000_4000;
    step();
    step(); hrdata = 32'hF0;
    step(); hrdata = 32'hF1;
    step(); hrdata = 32'hF2; #2;
    rst = 1'b0; mem_req = 1'b0; #1;
    chk("t5_rst_htrans", htrans, 2'b00);
    chk("t5_rst_haddr", haddr, 32'h0);
    chk("t5_rst_ready", mem_ready, 1'b0);
    chk("t5_rst_line", mem_data_in, 128'h0);
    step(); rst = 1'b1;
    step(); #1;
    chk("t5_idle1_htrans", htrans, 2'b00);
    step(); #1;
    chk("t5_idle2_htrans", htrans, 2'b00);
    chk("t5_idle2_ready", mem_ready, 1'b0);

    // 6: request held through reset release
    rst = 1'b0; mem_req = 1'b1; mem_addr = 32'h0000_6004;
    step(); #1;
    chk("t6_inrst_htrans", htrans, 2'b00);
    rst = 1'b1;
    step(); #1;
    chk("t6_c1_htrans", htrans, 2'b10);
    chk("t6_c1_haddr", haddr, 32'h6000);
    step(); hrdata = 32'h10;
    step(); hrdata = 32'h11;
    step(); hrdata = 32'h12;
    step(); hrdata = 32'h13;
    step(); #1;
    chk("t6_c6_ready", mem_ready, 1'b1);
    chk("t6_c6_line", mem_data_in, 128'h00000013_00000012_00000011_00000010);
    step(); mem_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
